// File: rtl/core_pkg.sv
// Shared core types: ALU operation encoding, ALU-share arbiter states and limits.
// Used by alu_share_arbiter (optional perf counters via `ALU_ARB_PERF_EN).
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_X    = 4'hF
  } alu_sel_e;

  localparam int ALU_SEL_W = $bits(alu_sel_e);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam int ALU_ARB_MAX_REQ = 8;
  localparam int PERF_CNT_W      = 16;

  // Saturating increment so a busy requester's counter pins at all-ones.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == {PERF_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after last_grant_i wins,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               gnt_any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant_i) + i) % NUM_REQ);
      if (!gnt_any_o && req_i[cand]) begin
        gnt_any_o   = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters, one op in flight, round-robin grant.
// Define `ALU_ARB_PERF_EN to add per-requester saturating accept counters (perf_grant_cnt_o).
//
//  state    | meaning
//  ARB_IDLE | waiting for a request; grant is combinational, payload latched on accept
//  ARB_EXEC | issue regs drive the ALU, result/err captured
//  ARB_RESP | response presented until rsp_ready_i
module alu_share_arbiter
  import core_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][ALU_SEL_W-1:0]   req_op_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]        req_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]        req_b_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag_i,
  output alu_sel_e                            alu_sel_o,
  output logic [XLEN-1:0]                     alu_a_o,
  output logic [XLEN-1:0]                     alu_b_o,
  input  logic [XLEN-1:0]                     alu_result_i,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id_o,
  output logic [TAG_W-1:0]                    rsp_tag_o,
  output logic [XLEN-1:0]                     rsp_result_o,
  output logic                                rsp_err_o
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][PERF_CNT_W-1:0]  perf_grant_cnt_o
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;

  alu_sel_e         iss_op_q, iss_op_d;
  logic [XLEN-1:0]  iss_a_q, iss_a_d;
  logic [XLEN-1:0]  iss_b_q, iss_b_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic [ID_W-1:0]  iss_id_q, iss_id_d;

  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [XLEN-1:0]  rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (ID_W)
  ) u_rr (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx),
    .gnt_any_o    (gnt_any)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      iss_op_q     <= ALU_ADD;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_tag_q    <= '0;
      iss_id_q     <= '0;
      rsp_id_q     <= '0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      iss_op_q     <= iss_op_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_tag_q    <= iss_tag_d;
      iss_id_q     <= iss_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    iss_op_d     = iss_op_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_tag_d    = iss_tag_q;
    iss_id_d     = iss_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    req_ready_o  = '0;
    alu_sel_o    = ALU_X;
    alu_a_o      = '0;
    alu_b_o      = '0;
    rsp_valid_o  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // No accept while reset is asserted: the payload would be thrown away.
        if (gnt_any && rst_ni) begin
          req_ready_o = gnt;
          iss_op_d    = alu_sel_e'(req_op_i[gnt_idx]);
          iss_a_d     = req_a_i[gnt_idx];
          iss_b_d     = req_b_i[gnt_idx];
          iss_tag_d   = req_tag_i[gnt_idx];
          iss_id_d    = gnt_idx;
          state_d     = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        alu_sel_o    = iss_op_q;
        alu_a_o      = iss_a_q;
        alu_b_o      = iss_b_q;
        rsp_err_d    = (iss_op_q == ALU_X);
        rsp_result_d = (iss_op_q == ALU_X) ? '0 : alu_result_i;
        rsp_id_d     = iss_id_q;
        rsp_tag_d    = iss_tag_q;
        last_grant_d = iss_id_q;
        state_d      = ARB_RESP;
      end
      ARB_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign rsp_id_o     = rsp_id_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][PERF_CNT_W-1:0] perf_cnt_q, perf_cnt_d;
  logic                               accept;

  assign accept = (state_q == ARB_IDLE) && gnt_any && rst_ni;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && gnt[i]) begin
        perf_cnt_d[i] = sat_inc(perf_cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_grant_cnt_o = perf_cnt_q;
`endif

endmodule
